serial_deser: RTL and testbench
===============================

SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 Parameter WIDTH, default 16, width of each received word.
REQ-002 Parameter WORDS, default 3, number of words per frame.
REQ-003 Parameter AW, default 11, width of the frame write-address counter.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  when low, no new frame is started; a frame in progress completes.
REQ-007 serial_in  input  1  serial line, same clock domain, one bit per clk, idles high.
REQ-008 addr_clear  input  1  one-cycle request to reset wr_addr to 0.
REQ-009 read_data1, read_data2, read_data3  output  WIDTH each  last good frame's words, in receive order.
REQ-010 frame_valid  output  1  one-cycle pulse: a good frame has been latched.
REQ-011 frame_error  output  1  one-cycle pulse: stop bit was 0.
REQ-012 wr_addr  output  AW  address tag of the frame latched by the current frame_valid pulse.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Frame format SHALL be: start bit 0, then WORDS*WIDTH (48) data bits MSB-first (read_data1[15] first, read_data3[0] last), then stop bit 1.
REQ-015 FSM states SHALL be IDLE, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE->DATA when enable=1 and serial_in=0; the start bit is consumed in that cycle.
REQ-017 DATA SHALL shift serial_in into a 48-bit shift register each cycle; a 6-bit bit counter counts 0..47; DATA->STOP after bit 47 is sampled.
REQ-018 STOP with serial_in=1: copy the shift register into read_data1..3, pulse frame_valid for one cycle, enter IDLE.
REQ-019 frame_valid and read_data1..3 SHALL become visible in the cycle after the stop bit is sampled (latency 50 clk from start-bit sample).
REQ-020 STOP with serial_in=0: pulse frame_error, leave read_data1..3 and wr_addr unchanged, enter WAIT_HIGH.
REQ-021 WAIT_HIGH->IDLE only when serial_in=1; no start bit is recognised in WAIT_HIGH.
REQ-022 wr_addr SHALL be updated together with frame_valid: the first good frame after reset or addr_clear carries 0, each later good frame carries the previous wr_addr+1.
REQ-023 wr_addr SHALL wrap from 2^AW-1 to 0 without any flag.
REQ-024 addr_clear SHALL set wr_addr to 0 and make the next good frame carry 0; if addr_clear coincides with a good stop bit, that frame carries 0 and the next carries 1.
REQ-025 An IDLE cycle with serial_in=1 only, or with enable=0, SHALL leave all state unchanged.
REQ-026 A start bit SHALL be accepted in the first IDLE cycle after STOP (back-to-back frames, 50 clk period).
REQ-027 enable falling mid-frame SHALL NOT abort the frame.

Reset
REQ-028 rst=1 SHALL, at the next edge, force state IDLE, bit counter 0, shift register 0, read_data1..3 0, wr_addr 0, frame_valid 0, frame_error 0, busy 0.
REQ-029 rst asserted mid-frame SHALL discard the partial frame; after rst deasserts, reception restarts only from a new start bit seen in IDLE.

Structure
REQ-030 State encoding, the WIDTH/WORDS/AW defaults and the frame length constant (WORDS*WIDTH+2) SHALL live in a shared package used by serial_deser and the transmit side.
REQ-031 The block SHALL be a single module with no sub-modules; the shift register and counters SHALL be inline.

Verification
REQ-032 Frame carrying 16'h1234, 16'hABCD, 16'h0F0F with stop=1 -> 50 clk after the start bit, frame_valid pulses once with those three outputs and wr_addr=0.
REQ-033 Same frame with stop=0 -> frame_error pulses, outputs keep their previous values, and a start bit 0 held during WAIT_HIGH is ignored until the line goes high.
REQ-034 2^AW+1 back-to-back good frames -> wr_addr runs 0..2047 then 0, and busy stays high between frames except for the one IDLE cycle.
REQ-035 rst pulsed at data bit 20, then a clean frame 16'hFFFF, 16'h0000, 16'h8001 -> only the clean frame is latched, with wr_addr=0.
REQ-036 addr_clear coincident with a good stop bit after 5 frames -> that frame reports wr_addr=0 and the next reports 1; enable=0 with start bits on the line -> no busy, no pulses.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared definitions for the serial frame receive and transmit sides.
// Holds FSM encoding, default geometry and frame length.
package serial_deser_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_WORDS = 3;
    localparam int DEF_AW    = 11;

    // start bit + data bits + stop bit
    localparam int FRAME_LEN = DEF_WORDS * DEF_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        WAIT_HIGH = 2'd3
    } rx_state_t;

    function automatic int frame_bits(input int words, input int width);
        return words * width + 2;
    endfunction

endpackage

// File: rtl/serial_deser.sv
// Serial frame deserializer: start bit, WORDS*WIDTH data bits MSB-first,
// stop bit; latches good frames with a wrapping address tag.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             addr_clear,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    output logic [WIDTH-1:0] read_data3,
    output logic             frame_valid,
    output logic             frame_error,
    output logic [AW-1:0]    wr_addr,
    output logic             busy
);

    localparam int NBITS = WORDS * WIDTH;
    localparam int CW    = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    rx_state_t state_q;
    rx_state_t state_d;

    logic [CW-1:0]    bit_cnt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] frame_q;
    logic [AW-1:0]    next_addr;

    logic cnt_clr;
    logic shift_en;
    logic good;
    logic bad;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !serial_in) begin
                    state_d = DATA;
                    cnt_clr = 1'b1;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (serial_in) begin
                    good    = 1'b1;
                    state_d = IDLE;
                end else begin
                    bad     = 1'b1;
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (serial_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift register, bit counter and frame latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            frame_q <= '0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (shift_en) begin
                shreg <= {shreg[NBITS-2:0], serial_in};
            end
            if (good) begin
                frame_q <= shreg;
            end
        end
    end

    // Address tagging: clear wins, and a clear on a good frame tags it 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr   <= '0;
            next_addr <= '0;
        end else if (addr_clear) begin
            wr_addr   <= '0;
            next_addr <= good ? AW'(1) : '0;
        end else if (good) begin
            wr_addr   <= next_addr;
            next_addr <= next_addr + AW'(1);
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= good;
            frame_error <= bad;
        end
    end

    assign read_data1 = frame_q[NBITS-1 -: WIDTH];
    assign read_data2 = frame_q[NBITS-1-WIDTH -: WIDTH];
    assign read_data3 = frame_q[WIDTH-1:0];
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_deser.sv
// Scoreboard bench for serial_deser: directed frames push expected
// pulses, a negedge monitor pops and compares them.
module tb_serial_deser;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          serial_in;
    logic          addr_clear;
    logic [W-1:0]  read_data1;
    logic [W-1:0]  read_data2;
    logic [W-1:0]  read_data3;
    logic          frame_valid;
    logic          frame_error;
    logic [AW-1:0] wr_addr;
    logic          busy;

    serial_deser #(.WIDTH(W), .WORDS(3), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .serial_in  (serial_in),
        .addr_clear (addr_clear),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .read_data3 (read_data3),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .wr_addr    (wr_addr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [W-1:0]  d1;
        logic [W-1:0]  d2;
        logic [W-1:0]  d3;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    int applied = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [W-1:0]  l1, l2, l3;
    logic [AW-1:0] l_addr;
    logic [AW-1:0] m_next;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (frame_valid || frame_error) begin
            if (sb.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL unexpected_pulse got fv=%b fe=%b exp none",
                         frame_valid, frame_error);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("frame_valid", {31'd0, frame_valid}, {31'd0, ~e.err});
                chk("frame_error", {31'd0, frame_error}, {31'd0, e.err});
                chk("read_data1", {16'd0, read_data1}, {16'd0, e.d1});
                chk("read_data2", {16'd0, read_data2}, {16'd0, e.d2});
                chk("read_data3", {16'd0, read_data3}, {16'd0, e.d3});
                chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        tick();
        rst = 1'b0;
        l1 = '0;
        l2 = '0;
        l3 = '0;
        l_addr = '0;
        m_next = '0;
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic stop,
                              input logic clr, input logic drop_en);
        logic [3*W-1:0] w;
        exp_t e;
        w = {a, b, c};
        e.cyc = cyc + 50;
        if (stop) begin
            e.err = 1'b0;
            e.d1 = a;
            e.d2 = b;
            e.d3 = c;
            e.addr = clr ? '0 : m_next;
            m_next = clr ? AW'(1) : m_next + AW'(1);
            l1 = a;
            l2 = b;
            l3 = c;
            l_addr = e.addr;
        end else begin
            e.err = 1'b1;
            e.d1 = l1;
            e.d2 = l2;
            e.d3 = l3;
            e.addr = l_addr;
        end
        sb.push_back(e);
        send_bit(1'b0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 3*W-1; i >= 0; i--) begin
            if (drop_en && i == 30) enable = 1'b0;
            send_bit(w[i]);
        end
        addr_clear = clr;
        send_bit(stop);
        addr_clear = 1'b0;
        enable = 1'b1;
        chk("busy_after_stop", {31'd0, busy}, {31'd0, ~stop});
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 1'b1;
        enable = 1'b1;
        serial_in = 1'b1;
        addr_clear = 1'b0;
        tick();
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fv", {31'd0, frame_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        chk("rst_rd1", {16'd0, read_data1}, 32'd0);
        chk("rst_rd3", {16'd0, read_data3}, 32'd0);
        chk("rst_addr", {27'd0, wr_addr}, 32'd0);
        send_bit(1'b1);

        send_frame(16'h1234, 16'hABCD, 16'h0F0F, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);

        send_frame(16'h1234, 16'hABCD, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0);
            chk("wait_high_busy", {31'd0, busy}, 32'd1);
        end
        send_bit(1'b1);
        chk("wait_high_exit", {31'd0, busy}, 32'd0);
        send_frame(16'h5555, 16'hAAAA, 16'h0001, 1'b1, 1'b0, 1'b0);

        send_bit(1'b0);
        for (int i = 0; i < 21; i++) send_bit(1'b1);
        do_reset();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rd2", {16'd0, read_data2}, 32'd0);
        chk("midrst_addr", {27'd0, wr_addr}, 32'd0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_frame(16'hFFFF, 16'h0000, 16'h8001, 1'b1, 1'b0, 1'b0);

        addr_clear = 1'b1;
        send_bit(1'b1);
        addr_clear = 1'b0;
        m_next = '0;
        chk("clear_idle", {27'd0, wr_addr}, 32'd0);
        for (int i = 0; i <= (1 << AW); i++) begin
            v = W'(i * 16'h0101);
            send_frame(v, ~v, W'(i), 1'b1, 1'b0, 1'b0);
        end
        send_bit(1'b1);

        for (int i = 0; i < 5; i++) begin
            v = W'(16'h1000 + i);
            send_frame(v, 16'hC3C3, ~v, 1'b1, 1'b0, i == 2);
        end
        send_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b0);
        send_frame(16'h0123, 16'h4567, 16'h89AB, 1'b1, 1'b0, 1'b0);

        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(i[0]);
            chk("disabled_busy", {31'd0, busy}, 32'd0);
        end
        serial_in = 1'b1;
        enable = 1'b1;
        send_bit(1'b1);
        send_frame(16'h7E57, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
